// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, the instruction memory and the IF/ID stage.
// master: the fetch unit side; slave: the memory / pipeline side.
interface fetch_unit_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_inst;
  logic [DW-1:0] if_inst;
  logic [AW-1:0] if_pc;
  logic          if_valid;

  modport master (
    input  stall, redirect, redirect_pc, imem_inst,
    output imem_addr, if_inst, if_pc, if_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_inst,
    input  imem_addr, if_inst, if_pc, if_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for a synchronous (1-cycle read latency)
// instruction memory. Tracks which PC the returned word belongs to, holds
// the instruction on stall by replaying the address, and redirects with no
// bubble by steering the memory address combinationally.
// Optional macro FETCH_PERF_EN adds handoff and redirect counters.
module fetch_unit #(
  parameter int            AW       = 8,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [15:0]   redirect_count
`endif
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pend_pc;
  logic          pend_valid;
  logic [AW-1:0] addr_sel;

  // Choose the memory address: redirect target, replayed PC on stall, else sequential PC.
  always_comb begin
    addr_sel = pc;
    if (rst) begin
      addr_sel = RESET_PC;
    end else if (bus.redirect) begin
      addr_sel = bus.redirect_pc;
    end else if (bus.stall && pend_valid) begin
      addr_sel = pend_pc;
    end
  end

  assign bus.imem_addr = addr_sel;
  assign bus.if_valid  = pend_valid;
  assign bus.if_pc     = pend_pc;
  assign bus.if_inst   = pend_valid ? bus.imem_inst : '0;

  // Track the sequential PC and the PC whose word the memory returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
    end else if (bus.redirect) begin
      pend_pc    <= bus.redirect_pc;
      pend_valid <= 1'b1;
      pc         <= bus.redirect_pc + 1'b1;
    end else if (!bus.stall) begin
      pend_pc    <= pc;
      pend_valid <= 1'b1;
      pc         <= pc + 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  logic handoff;
  assign handoff = pend_valid && !bus.stall && !bus.redirect;

  // Count instructions handed to decode and taken redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (handoff) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (bus.redirect) begin
        redirect_count <= redirect_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. Memory word i holds i << 8, so the
// expected instruction for any PC is derived directly from the PC.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] mem [256];

  fetch_unit_if #(.AW(8), .DW(32)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;
  fetch_unit #(.AW(8), .DW(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .fetch_count(fetch_count), .redirect_count(redirect_count)
  );
`else
  fetch_unit #(.AW(8), .DW(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory model with one cycle read latency.
  always @(posedge clk) bus.imem_inst <= mem[bus.imem_addr];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, release off-edge; returns just after release.
  task automatic do_reset();
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.if_valid);
    end
    checks++;
    if (bus.if_inst !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_inst: got %h expected 00000000", bus.if_inst);
    end
    checks++;
    if (bus.if_pc !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_pc: got %h expected 00", bus.if_pc);
    end
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_addr: got %h expected 00", bus.imem_addr);
    end
  endtask

  task automatic test_free_run();
    logic [7:0]  exp_pc   [3];
    logic [31:0] exp_inst [3];
    exp_pc   = '{8'h00, 8'h01, 8'h02};
    exp_inst = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0200};
    do_reset();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL first_cycle_valid: got %b expected 0", bus.if_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== exp_pc[k] || bus.if_inst !== exp_inst[k]) begin
        errors++;
        $display("[TB] FAIL free_run[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, exp_pc[k], exp_inst[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    bus.stall = 1'b1;
    #1;
    checks++;
    if (bus.imem_addr !== 8'h01) begin
      errors++; $display("[TB] FAIL stall_replay_addr: got %h expected 01", bus.imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h01 || bus.if_inst !== 32'h0000_0100
          || bus.imem_addr !== 8'h01) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h addr=%h expected v=1 pc=01 inst=00000100 addr=01",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, bus.imem_addr);
      end
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.if_pc !== 8'h02 || bus.if_inst !== 32'h0000_0200) begin
      errors++;
      $display("[TB] FAIL stall_release: got pc=%h inst=%h expected pc=02 inst=00000200",
               bus.if_pc, bus.if_inst);
    end
  endtask

  task automatic test_stall_empty();
    rst = 1'b1;
    bus.stall = 1'b1;
    bus.redirect = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++; $display("[TB] FAIL stall_empty_addr: got %h expected 00", bus.imem_addr);
    end
    tick();
    tick();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL stall_empty_hold: got v=%b addr=%h expected v=0 addr=00",
               bus.if_valid, bus.imem_addr);
    end
    bus.stall = 1'b0;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h00) begin
      errors++;
      $display("[TB] FAIL stall_empty_release: got v=%b pc=%h expected v=1 pc=00",
               bus.if_valid, bus.if_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (6) tick();
    checks++;
    if (bus.if_pc !== 8'h05) begin
      errors++; $display("[TB] FAIL redirect_pre_pc: got %h expected 05", bus.if_pc);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    #1;
    checks++;
    if (bus.imem_addr !== 8'h40) begin
      errors++; $display("[TB] FAIL redirect_addr: got %h expected 40", bus.imem_addr);
    end
    tick();
    bus.redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] epc;
      epc = 8'h40 + 8'(k);
      if (k > 0) tick();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== epc || bus.if_inst !== {16'h0, epc, 8'h00}) begin
        errors++;
        $display("[TB] FAIL redirect_seq[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 k, bus.if_valid, bus.if_pc, bus.if_inst, epc, {16'h0, epc, 8'h00});
      end
    end
  endtask

  task automatic test_redirect_stall();
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    #1;
    checks++;
    if (bus.imem_addr !== 8'h10) begin
      errors++; $display("[TB] FAIL redir_stall_addr: got %h expected 10", bus.imem_addr);
    end
    tick();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    checks++;
    if (bus.if_pc !== 8'h10 || bus.if_inst !== 32'h0000_1000) begin
      errors++;
      $display("[TB] FAIL redir_stall_pc: got pc=%h inst=%h expected pc=10 inst=00001000",
               bus.if_pc, bus.if_inst);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFE;
    tick();
    bus.redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (bus.if_pc !== exp_pc[k] || bus.if_inst !== {16'h0, exp_pc[k], 8'h00}) begin
        errors++;
        $display("[TB] FAIL wrap[%0d]: got pc=%h inst=%h expected pc=%h inst=%h",
                 k, bus.if_pc, bus.if_inst, exp_pc[k], {16'h0, exp_pc[k], 8'h00});
      end
    end
  endtask

  task automatic test_reset_midstream();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 8'h00 || bus.if_inst !== 32'h0 || bus.if_pc !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got v=%b addr=%h inst=%h pc=%h expected v=0 addr=00 inst=00000000 pc=00",
               bus.if_valid, bus.imem_addr, bus.if_inst, bus.if_pc);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h00 || bus.if_inst !== 32'h0) begin
      errors++;
      $display("[TB] FAIL after_reset: got v=%b pc=%h inst=%h expected v=1 pc=00 inst=00000000",
               bus.if_valid, bus.if_pc, bus.if_inst);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++;
    if (fetch_count !== 32'd0 || redirect_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got fc=%0d rc=%0d expected fc=0 rc=0", fetch_count, redirect_count);
    end
    tick();
    repeat (10) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    repeat (2) tick();
    bus.redirect = 1'b0;
    checks++;
    if (fetch_count !== 32'd10 || redirect_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL perf_count: got fc=%0d rc=%0d expected fc=10 rc=2", fetch_count, redirect_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_count !== 32'd0 || redirect_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL perf_clear: got fc=%0d rc=%0d expected fc=0 rc=0", fetch_count, redirect_count);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = {16'h0, 8'(i), 8'h00};
    test_reset();
    test_free_run();
    test_stall();
    test_stall_empty();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_midstream();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
